// File: rtl/io_pkg.sv
// Shared constants for the board IO input-conditioning path.
package io_pkg;
  localparam int TICK_CYCLES_DEF  = 100000;
  localparam int STABLE_TICKS_DEF = 4;
  localparam int N_SW_DEF         = 16;
  localparam int N_BTN_DEF        = 2;

  localparam int BTN_L = 0;
  localparam int BTN_R = 1;
endpackage

// File: rtl/io_debounce_db_bit.sv
// One input bit: 2-flop synchroniser, tick-sampled history, hysteretic level,
// and registered rise/change strobes aligned with the level update.
module db_bit
  import io_pkg::*;
#(
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic clk,
  input  logic reset,
  input  logic tick,
  input  logic raw,
  output logic level,
  output logic rise,
  output logic change
);

  logic                    sync1, sync2;
  logic [STABLE_TICKS-1:0] hist;
  logic                    next_level;

  // Level only moves on a unanimous history; mixed samples hold it.
  always_comb begin
    next_level = level;
    if (&hist)       next_level = 1'b1;
    else if (~|hist) next_level = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1  <= 1'b0;
      sync2  <= 1'b0;
      hist   <= '0;
      level  <= 1'b0;
      rise   <= 1'b0;
      change <= 1'b0;
    end else begin
      sync1  <= raw;
      sync2  <= sync1;
      if (tick) hist <= {hist[STABLE_TICKS-2:0], sync2};
      level  <= next_level;
      rise   <= next_level & ~level;
      change <= next_level ^ level;
    end
  end

endmodule

// File: rtl/io_debounce.sv
// Button/switch conditioning: shared sample tick, per-bit debounce lanes,
// press pulses, sticky press flags (W1C) and a switch-change event.
module io_debounce
  import io_pkg::*;
#(
  parameter int N_BTN        = N_BTN_DEF,
  parameter int N_SW         = N_SW_DEF,
  parameter int TICK_CYCLES  = TICK_CYCLES_DEF,
  parameter int STABLE_TICKS = STABLE_TICKS_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [N_BTN-1:0] btn_raw,
  input  logic [N_SW-1:0]  sw_raw,
  input  logic [N_BTN-1:0] btn_clr,
  output logic [N_BTN-1:0] btn_level,
  output logic [N_BTN-1:0] btn_press,
  output logic [N_BTN-1:0] btn_sticky,
  output logic [N_SW-1:0]  sw_level,
  output logic             sw_evt
);

  localparam int CW = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam int NB = N_BTN + N_SW;

  logic [CW-1:0] cnt;
  logic          tick;

  assign tick = (cnt == CW'(TICK_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset)     cnt <= '0;
    else if (tick) cnt <= '0;
    else           cnt <= cnt + 1'b1;
  end

  logic [NB-1:0] raw_all, lvl, rise, chg;
  assign raw_all = {sw_raw, btn_raw};

  for (genvar gi = 0; gi < NB; gi++) begin : g_db
    db_bit #(.STABLE_TICKS(STABLE_TICKS)) u_db (
      .clk    (clk),
      .reset  (reset),
      .tick   (tick),
      .raw    (raw_all[gi]),
      .level  (lvl[gi]),
      .rise   (rise[gi]),
      .change (chg[gi])
    );
  end

  // Buttons only need rise, switches only need change.
  logic [N_BTN-1:0] btn_chg_unused;
  logic [N_SW-1:0]  sw_rise_unused;
  assign btn_chg_unused = chg[N_BTN-1:0];
  assign sw_rise_unused = rise[NB-1:N_BTN];

  assign btn_level = lvl[N_BTN-1:0];
  assign btn_press = rise[N_BTN-1:0];
  assign sw_level  = lvl[NB-1:N_BTN];
  assign sw_evt    = |chg[NB-1:N_BTN];

  // A press arriving with a clear wins so no press is lost.
  always_ff @(posedge clk) begin
    if (reset) btn_sticky <= '0;
    else       btn_sticky <= (btn_sticky & ~btn_clr) | btn_press;
  end

endmodule

// File: tb/tb_io_debounce.sv
// Scenario bench for io_debounce with a short tick (4 cycles) and 3-sample window.
module tb_io_debounce;
  localparam int NB = 2;
  localparam int NS = 16;
  localparam int TC = 4;
  localparam int ST = 3;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [NB-1:0] btn_raw = '0, btn_clr = '0;
  logic [NS-1:0] sw_raw = '0;
  logic [NB-1:0] btn_level, btn_press, btn_sticky;
  logic [NS-1:0] sw_level;
  logic          sw_evt;

  int            n_checks = 0;
  int            n_fail = 0;
  int            press_q[$];
  logic [NS-1:0] sw_q[$];

  always #5 clk = ~clk;

  io_debounce #(.N_BTN(NB), .N_SW(NS), .TICK_CYCLES(TC), .STABLE_TICKS(ST)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .sw_raw     (sw_raw),
    .btn_clr    (btn_clr),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_sticky (btn_sticky),
    .sw_level   (sw_level),
    .sw_evt     (sw_evt)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic apply_reset(input int cycles);
    reset = 1'b1;
    repeat (cycles) step();
    reset = 1'b0;
  endtask

  task automatic test_reset();
    btn_raw = '0; sw_raw = '0; btn_clr = '0;
    apply_reset(2);
    for (int k = 1; k <= 20; k++) begin
      step();
      n_checks++;
      if ({btn_level, btn_press, btn_sticky, sw_level, sw_evt} !== '0) begin
        n_fail++;
        $display("FAIL reset_outputs cycle %0d got lvl=%b prs=%b stk=%b sw=%h evt=%b exp all 0",
                 k, btn_level, btn_press, btn_sticky, sw_level, sw_evt);
      end
      if (k <= 5) begin
        n_checks++;
        if (dut.cnt !== 2'(k % 4)) begin
          n_fail++;
          $display("FAIL reset_cnt cycle %0d got %0d exp %0d", k, dut.cnt, k % 4);
        end
      end
    end
  endtask

  task automatic test_btn_press();
    int rise_at = -1, press_at = -1, sticky_at = -1, press_n = 0, e;
    btn_raw = 2'b01;
    apply_reset(2);
    press_q.push_back(0);
    for (int k = 1; k <= 30; k++) begin
      step();
      if (btn_level[0] && rise_at < 0) rise_at = k;
      if (btn_sticky[0] && sticky_at < 0) sticky_at = k;
      if (btn_press != '0) begin
        press_n++;
        press_at = k;
        n_checks++;
        if (press_q.size() == 0) begin
          n_fail++;
          $display("FAIL press_unexpected cycle %0d got %b exp none", k, btn_press);
        end else begin
          e = press_q.pop_front();
          if (btn_press !== NB'(1 << e)) begin
            n_fail++;
            $display("FAIL press_bits got %b exp %b", btn_press, NB'(1 << e));
          end
        end
      end
    end
    n_checks++;
    if (rise_at < 11 || rise_at > 16) begin
      n_fail++;
      $display("FAIL press_latency got %0d exp 11..16", rise_at);
    end
    n_checks++;
    if (press_n != 1) begin
      n_fail++;
      $display("FAIL press_count got %0d exp 1", press_n);
    end
    n_checks++;
    if (press_at != rise_at) begin
      n_fail++;
      $display("FAIL press_align got %0d exp %0d", press_at, rise_at);
    end
    n_checks++;
    if (sticky_at != rise_at + 1) begin
      n_fail++;
      $display("FAIL sticky_set got %0d exp %0d", sticky_at, rise_at + 1);
    end
    n_checks++;
    if (press_q.size() != 0) begin
      n_fail++;
      $display("FAIL press_missing got %0d pending exp 0", press_q.size());
    end
  endtask

  task automatic test_glitch();
    for (int k = 0; k < 60; k++) begin
      if (k % 3 == 0) btn_raw[1] = ~btn_raw[1];
      step();
      n_checks++;
      if ({btn_press, btn_level[1], btn_sticky[1]} !== 4'b0) begin
        n_fail++;
        $display("FAIL glitch cycle %0d got prs=%b lvl1=%b stk1=%b exp 0",
                 k, btn_press, btn_level[1], btn_sticky[1]);
      end
    end
    btn_raw[1] = 1'b0;
  endtask

  task automatic test_sticky_clr();
    bit done;
    int e;
    n_checks++;
    if (btn_sticky !== 2'b01) begin
      n_fail++;
      $display("FAIL sticky_pre got %b exp 01", btn_sticky);
    end
    btn_clr = 2'b01;
    step();
    btn_clr = 2'b00;
    n_checks++;
    if (btn_sticky[0] !== 1'b0) begin
      n_fail++;
      $display("FAIL sticky_clear got %b exp 0", btn_sticky[0]);
    end
    // Release: level must fall with no pulse and no sticky change.
    btn_raw[0] = 1'b0;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      step();
      n_checks++;
      if (btn_press !== 2'b00 || btn_sticky !== 2'b00) begin
        n_fail++;
        $display("FAIL release_quiet got prs=%b stk=%b exp 00/00", btn_press, btn_sticky);
      end
      if (btn_level[0] == 1'b0) done = 1;
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL release_timeout got level=%b exp 0", btn_level[0]);
    end
    // New press with a clear landing in the press cycle.
    btn_raw[0] = 1'b1;
    press_q.push_back(0);
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      step();
      if (btn_press[0]) begin
        done = 1;
        e = press_q.pop_front();
        n_checks++;
        if (btn_press !== NB'(1 << e) || btn_sticky[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL reclr_press got prs=%b stk=%b exp %b/0", btn_press, btn_sticky[0], NB'(1 << e));
        end
        btn_clr = 2'b01;
        step();
        btn_clr = 2'b00;
        n_checks++;
        if (btn_sticky[0] !== 1'b1 || btn_press[0] !== 1'b0) begin
          n_fail++;
          $display("FAIL set_wins got stk=%b prs=%b exp 1/0", btn_sticky[0], btn_press[0]);
        end
      end
    end
    n_checks++;
    if (!done) begin
      n_fail++;
      $display("FAIL repress_timeout got level=%b exp press", btn_level[0]);
    end
  endtask

  task automatic sw_phase(input logic [NS-1:0] from, input logic [NS-1:0] to, input string tag);
    int evt_n = 0, evt_at = -1, chg_at = -1;
    logic [NS-1:0] prev, e;
    prev = sw_level;
    sw_raw = to;
    sw_q.push_back(to);
    for (int k = 1; k <= 30; k++) begin
      step();
      n_checks++;
      if (sw_level !== from && sw_level !== to) begin
        n_fail++;
        $display("FAIL %s_partial cycle %0d got %h exp %h or %h", tag, k, sw_level, from, to);
      end
      if (sw_level !== prev && chg_at < 0) chg_at = k;
      prev = sw_level;
      if (sw_evt) begin
        evt_n++;
        evt_at = k;
        if (sw_q.size() != 0) begin
          e = sw_q.pop_front();
          n_checks++;
          if (sw_level !== e) begin
            n_fail++;
            $display("FAIL %s_evt_level got %h exp %h", tag, sw_level, e);
          end
        end
      end
    end
    n_checks++;
    if (evt_n != 1) begin
      n_fail++;
      $display("FAIL %s_evt_count got %0d exp 1", tag, evt_n);
    end
    n_checks++;
    if (evt_at != chg_at || chg_at < 0) begin
      n_fail++;
      $display("FAIL %s_evt_align got %0d exp %0d", tag, evt_at, chg_at);
    end
    n_checks++;
    if (sw_level !== to) begin
      n_fail++;
      $display("FAIL %s_final got %h exp %h", tag, sw_level, to);
    end
  endtask

  task automatic test_sw();
    sw_phase(16'h0000, 16'hA5A5, "sw_up");
    sw_phase(16'hA5A5, 16'h0000, "sw_down");
  endtask

  task automatic test_reset_mid();
    bit done;
    int press_at = -1, e;
    // Bring button 0 low again while sticky stays set from the earlier press.
    btn_raw[0] = 1'b0;
    done = 0;
    for (int k = 0; k < 30 && !done; k++) begin
      step();
      if (btn_level[0] == 1'b0) done = 1;
    end
    btn_raw[0] = 1'b1;
    repeat (9) step();
    n_checks++;
    if (btn_level[0] !== 1'b0 || btn_sticky[0] !== 1'b1) begin
      n_fail++;
      $display("FAIL mid_pre got lvl=%b stk=%b exp 0/1", btn_level[0], btn_sticky[0]);
    end
    apply_reset(1);
    n_checks++;
    if ({btn_level, btn_press, btn_sticky, sw_level, sw_evt} !== '0) begin
      n_fail++;
      $display("FAIL mid_reset got lvl=%b prs=%b stk=%b sw=%h evt=%b exp all 0",
               btn_level, btn_press, btn_sticky, sw_level, sw_evt);
    end
    press_q.push_back(0);
    for (int k = 1; k <= 30 && press_at < 0; k++) begin
      step();
      if (btn_press != '0) begin
        press_at = k;
        e = press_q.pop_front();
        n_checks++;
        if (btn_press !== NB'(1 << e)) begin
          n_fail++;
          $display("FAIL mid_press_bits got %b exp %b", btn_press, NB'(1 << e));
        end
      end
    end
    n_checks++;
    if (press_at < 11 || press_at > 16) begin
      n_fail++;
      $display("FAIL mid_press_latency got %0d exp 11..16", press_at);
    end
  endtask

  initial begin
    test_reset();
    test_btn_press();
    test_glitch();
    test_sticky_clr();
    test_sw();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
